// File: rtl/rob_multiport.sv
// Reorder buffer: in-order allocate, out-of-order complete, in-order retire of up to CMT_W per cycle.
// Latency: dispatch->commit min 2 cycles; commit/exc outputs are combinational from state (+cmt_ready_i).
// Backpressure: disp_ready_o drops when fewer than DISP_W slots are free; partial rollback under ROB_ROLLBACK_EN.
module rob_multiport #(
    parameter int DEPTH  = 64,
    parameter int DISP_W = 2,
    parameter int WB_W   = 2,
    parameter int CMT_W  = 2,
    parameter int DATA_W = 32,
    parameter int TAG_W  = $clog2(DEPTH) + 1
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           flush_i,
    input  logic [DISP_W-1:0]              disp_valid_i,
    input  logic [DISP_W-1:0][4:0]         disp_areg_i,
    input  logic [DISP_W-1:0]              disp_wreg_i,
    input  logic [DISP_W-1:0][31:0]        disp_pc_i,
    output logic                           disp_ready_o,
    output logic [DISP_W-1:0][TAG_W-1:0]   disp_tag_o,
    input  logic [WB_W-1:0]                wb_valid_i,
    input  logic [WB_W-1:0][TAG_W-1:0]     wb_tag_i,
    input  logic [WB_W-1:0][DATA_W-1:0]    wb_data_i,
    input  logic [WB_W-1:0]                wb_exc_i,
    input  logic                           cmt_ready_i,
    output logic [CMT_W-1:0]               cmt_valid_o,
    output logic [CMT_W-1:0][4:0]          cmt_areg_o,
    output logic [CMT_W-1:0]               cmt_wreg_o,
    output logic [CMT_W-1:0][31:0]         cmt_pc_o,
    output logic [CMT_W-1:0][DATA_W-1:0]   cmt_data_o,
    output logic                           exc_o,
    output logic [31:0]                    exc_pc_o,
`ifdef ROB_ROLLBACK_EN
    input  logic                           rb_valid_i,
    input  logic [TAG_W-1:0]               rb_tag_i,
`endif
    output logic [TAG_W-1:0]               count_o,
    output logic                           empty_o,
    output logic                           full_o
);
    localparam int IDX_W = TAG_W - 1;

    logic [TAG_W-1:0]  head_q, head_d, tail_q, tail_d;
    logic [DEPTH-1:0]  valid_q, valid_d, cmpl_q, cmpl_d, exc_q, exc_d;
    logic [DEPTH-1:0]  wrap_q, wrap_d, wreg_q, wreg_d;
    logic [4:0]        areg_q [DEPTH];
    logic [4:0]        areg_d [DEPTH];
    logic [31:0]       pc_q   [DEPTH];
    logic [31:0]       pc_d   [DEPTH];
    logic [DATA_W-1:0] data_q [DEPTH];
    logic [DATA_W-1:0] data_d [DEPTH];

    logic [TAG_W-1:0]  count, n_cmt, n_disp, n_kill;
    logic [TAG_W:0]    free_slots;
    logic [IDX_W-1:0]  head_idx, c_idx, w_idx, d_idx, k_off;
    logic              cmt_ok;
    logic              rb_fire;
    logic [TAG_W-1:0]  rb_tag;

`ifdef ROB_ROLLBACK_EN
    assign rb_fire = rb_valid_i;
    assign rb_tag  = rb_tag_i;
`else
    assign rb_fire = 1'b0;
    assign rb_tag  = '0;
`endif

    assign head_idx     = head_q[IDX_W-1:0];
    assign count        = tail_q - head_q;
    assign count_o      = count;
    assign empty_o      = (count == '0);
    assign full_o       = (count == TAG_W'(DEPTH));
    assign free_slots   = (TAG_W+1)'(DEPTH) - {1'b0, count};
    assign disp_ready_o = (free_slots >= (TAG_W+1)'(DISP_W));
    assign exc_o        = valid_q[head_idx] & cmpl_q[head_idx] & exc_q[head_idx];
    assign exc_pc_o     = exc_o ? pc_q[head_idx] : 32'h0;

    always_comb begin
        for (int i = 0; i < DISP_W; i++) begin
            disp_tag_o[i] = tail_q + TAG_W'(i);
        end
    end

    // A lane retires only if every older lane in the group retires too, keeping cmt_valid_o packed.
    always_comb begin
        cmt_valid_o = '0;
        cmt_areg_o  = '0;
        cmt_wreg_o  = '0;
        cmt_pc_o    = '0;
        cmt_data_o  = '0;
        n_cmt       = '0;
        c_idx       = '0;
        cmt_ok      = cmt_ready_i;
        for (int k = 0; k < CMT_W; k++) begin
            c_idx  = head_idx + IDX_W'(k);
            cmt_ok = cmt_ok && (TAG_W'(k) < count) && valid_q[c_idx]
                     && cmpl_q[c_idx] && !exc_q[c_idx];
            if (cmt_ok) begin
                cmt_valid_o[k] = 1'b1;
                cmt_areg_o[k]  = areg_q[c_idx];
                cmt_wreg_o[k]  = wreg_q[c_idx];
                cmt_pc_o[k]    = pc_q[c_idx];
                cmt_data_o[k]  = data_q[c_idx];
                n_cmt          = n_cmt + TAG_W'(1);
            end
        end
    end

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        valid_d = valid_q;
        cmpl_d  = cmpl_q;
        exc_d   = exc_q;
        wrap_d  = wrap_q;
        wreg_d  = wreg_q;
        areg_d  = areg_q;
        pc_d    = pc_q;
        data_d  = data_q;
        n_disp  = '0;
        n_kill  = '0;
        w_idx   = '0;
        d_idx   = '0;
        k_off   = '0;

        // Later ports overwrite earlier ones; the stored wrap bit filters stale tags.
        for (int p = 0; p < WB_W; p++) begin
            w_idx = wb_tag_i[p][IDX_W-1:0];
            if (wb_valid_i[p] && valid_q[w_idx] && (wrap_q[w_idx] == wb_tag_i[p][TAG_W-1])) begin
                cmpl_d[w_idx] = 1'b1;
                exc_d[w_idx]  = wb_exc_i[p];
                data_d[w_idx] = wb_data_i[p];
            end
        end

        for (int k = 0; k < CMT_W; k++) begin
            if (cmt_valid_o[k]) begin
                valid_d[head_idx + IDX_W'(k)] = 1'b0;
            end
        end
        head_d = head_q + n_cmt;

        if (rb_fire) begin
            tail_d = rb_tag + TAG_W'(1);
            n_kill = tail_q - rb_tag - TAG_W'(1);
            for (int j = 0; j < DEPTH; j++) begin
                k_off = IDX_W'(j) - rb_tag[IDX_W-1:0] - IDX_W'(1);
                if ({1'b0, k_off} < n_kill) begin
                    valid_d[j] = 1'b0;
                end
            end
        end else if (disp_ready_o) begin
            for (int i = 0; i < DISP_W; i++) begin
                if (disp_valid_i[i]) begin
                    d_idx         = disp_tag_o[i][IDX_W-1:0];
                    valid_d[d_idx] = 1'b1;
                    cmpl_d[d_idx]  = 1'b0;
                    exc_d[d_idx]   = 1'b0;
                    wrap_d[d_idx]  = disp_tag_o[i][TAG_W-1];
                    wreg_d[d_idx]  = disp_wreg_i[i];
                    areg_d[d_idx]  = disp_areg_i[i];
                    pc_d[d_idx]    = disp_pc_i[i];
                    data_d[d_idx]  = '0;
                    n_disp         = n_disp + TAG_W'(1);
                end
            end
            tail_d = tail_q + n_disp;
        end

        if (flush_i) begin
            head_d  = '0;
            tail_d  = '0;
            valid_d = '0;
            cmpl_d  = '0;
            exc_d   = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            valid_q <= '0;
            cmpl_q  <= '0;
            exc_q   <= '0;
            wrap_q  <= '0;
            wreg_q  <= '0;
            for (int j = 0; j < DEPTH; j++) begin
                areg_q[j] <= '0;
                pc_q[j]   <= '0;
                data_q[j] <= '0;
            end
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            valid_q <= valid_d;
            cmpl_q  <= cmpl_d;
            exc_q   <= exc_d;
            wrap_q  <= wrap_d;
            wreg_q  <= wreg_d;
            areg_q  <= areg_d;
            pc_q    <= pc_d;
            data_q  <= data_d;
        end
    end
endmodule

// File: tb/tb_rob_multiport.sv
// Bench for rob_multiport at DEPTH=8: scoreboard of expected retirements plus directed status checks.
module tb_rob_multiport;
    localparam int DEPTH = 8, DISP_W = 2, WB_W = 2, CMT_W = 2, DATA_W = 32, TAG_W = 4;
    localparam logic [31:0] DMASK = 32'hDA7A_0000;

    logic clk = 1'b0, rst, flush_i, disp_ready_o, cmt_ready_i, exc_o, empty_o, full_o;
    logic [DISP_W-1:0]            disp_valid_i, disp_wreg_i;
    logic [DISP_W-1:0][4:0]       disp_areg_i;
    logic [DISP_W-1:0][31:0]      disp_pc_i;
    logic [DISP_W-1:0][TAG_W-1:0] disp_tag_o;
    logic [WB_W-1:0]              wb_valid_i, wb_exc_i;
    logic [WB_W-1:0][TAG_W-1:0]   wb_tag_i;
    logic [WB_W-1:0][DATA_W-1:0]  wb_data_i;
    logic [CMT_W-1:0]             cmt_valid_o, cmt_wreg_o;
    logic [CMT_W-1:0][4:0]        cmt_areg_o;
    logic [CMT_W-1:0][31:0]       cmt_pc_o;
    logic [CMT_W-1:0][DATA_W-1:0] cmt_data_o;
    logic [31:0]                  exc_pc_o;
    logic [TAG_W-1:0]             count_o;
`ifdef ROB_ROLLBACK_EN
    logic             rb_valid_i;
    logic [TAG_W-1:0] rb_tag_i;
`endif

    rob_multiport #(.DEPTH(DEPTH), .DISP_W(DISP_W), .WB_W(WB_W), .CMT_W(CMT_W), .DATA_W(DATA_W)) dut (
        .clk(clk), .rst(rst), .flush_i(flush_i),
        .disp_valid_i(disp_valid_i), .disp_areg_i(disp_areg_i), .disp_wreg_i(disp_wreg_i),
        .disp_pc_i(disp_pc_i), .disp_ready_o(disp_ready_o), .disp_tag_o(disp_tag_o),
        .wb_valid_i(wb_valid_i), .wb_tag_i(wb_tag_i), .wb_data_i(wb_data_i), .wb_exc_i(wb_exc_i),
        .cmt_ready_i(cmt_ready_i), .cmt_valid_o(cmt_valid_o), .cmt_areg_o(cmt_areg_o),
        .cmt_wreg_o(cmt_wreg_o), .cmt_pc_o(cmt_pc_o), .cmt_data_o(cmt_data_o),
        .exc_o(exc_o), .exc_pc_o(exc_pc_o),
`ifdef ROB_ROLLBACK_EN
        .rb_valid_i(rb_valid_i), .rb_tag_i(rb_tag_i),
`endif
        .count_o(count_o), .empty_o(empty_o), .full_o(full_o)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] pc;
        logic [4:0]  areg;
        logic        wreg;
        logic [31:0] data;
    } exp_t;

    exp_t             sb_q[$];
    exp_t             mon_e;
    int               tests_run = 0, tests_failed = 0;
    int               seq = 0;
    logic [31:0]      m_pc [16];
    logic [TAG_W-1:0] m_tail = '0;

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    // Every retirement must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (!rst) begin
            for (int k = 0; k < CMT_W; k++) begin
                if (cmt_valid_o[k]) begin
                    if (sb_q.size() == 0) begin
                        check_eq("cmt_unexpected", 64'(k + 1), 64'h0);
                    end else begin
                        mon_e = sb_q.pop_front();
                        check_eq("cmt_pc",   cmt_pc_o[k],   mon_e.pc);
                        check_eq("cmt_data", cmt_data_o[k], mon_e.data);
                        check_eq("cmt_areg", cmt_areg_o[k], mon_e.areg);
                        check_eq("cmt_wreg", cmt_wreg_o[k], mon_e.wreg);
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #3;
    endtask

    task automatic drive_lanes(input int n);
        for (int i = 0; i < DISP_W; i++) begin
            disp_valid_i[i] = (i < n);
            disp_pc_i[i]    = 32'h1000 + 32'((seq + i) * 4);
            disp_areg_i[i]  = 5'(seq + i + 3);
            disp_wreg_i[i]  = ((seq + i) % 2 == 1);
        end
    endtask

    task automatic disp(input int n, input bit exp_rdy);
        exp_t e;
        drive_lanes(n);
        settle();
        check_eq("disp_rdy",  disp_ready_o,  exp_rdy);
        check_eq("disp_tag0", disp_tag_o[0], m_tail);
        check_eq("disp_tag1", disp_tag_o[1], 4'(m_tail + 4'd1));
        if (exp_rdy) begin
            for (int i = 0; i < n; i++) begin
                e.pc = disp_pc_i[i]; e.areg = disp_areg_i[i]; e.wreg = disp_wreg_i[i];
                e.data = disp_pc_i[i] ^ DMASK;
                sb_q.push_back(e);
                m_pc[m_tail] = disp_pc_i[i];
                m_tail = m_tail + 4'd1;
            end
        end
        seq += n;
        tick();
        disp_valid_i = '0;
    endtask

    task automatic wb(input bit v0, input int t0, input bit e0, input bit v1, input int t1, input bit e1);
        wb_valid_i   = {v1, v0};
        wb_exc_i     = {e1, e0};
        wb_tag_i[0]  = TAG_W'(t0);
        wb_tag_i[1]  = TAG_W'(t1);
        wb_data_i[0] = m_pc[t0] ^ DMASK;
        wb_data_i[1] = m_pc[t1] ^ DMASK;
        tick();
        wb_valid_i = '0;
        wb_exc_i   = '0;
    endtask

    task automatic do_flush();
        flush_i = 1'b1;
        tick();
        flush_i = 1'b0;
        sb_q.delete();
        m_tail = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 16; i++) m_pc[i] = '0;
        rst = 1'b1; flush_i = 1'b0; cmt_ready_i = 1'b1;
        disp_valid_i = '0; disp_wreg_i = '0; disp_areg_i = '0; disp_pc_i = '0;
        wb_valid_i = '0; wb_exc_i = '0; wb_tag_i = '0; wb_data_i = '0;
`ifdef ROB_ROLLBACK_EN
        rb_valid_i = 1'b0; rb_tag_i = '0;
`endif
        repeat (3) tick();
        rst = 1'b0;
        settle();
        check_eq("rst_count", count_o, 0);
        check_eq("rst_empty", empty_o, 1);
        check_eq("rst_full",  full_o, 0);
        check_eq("rst_ready", disp_ready_o, 1);
        check_eq("rst_cmt",   cmt_valid_o, 0);
        check_eq("rst_exc",   {exc_o, exc_pc_o}, 0);
        check_eq("rst_tags",  disp_tag_o, 8'h10);
        check_eq("rst_cmtpc", cmt_pc_o, 0);

        // Out-of-order completion, then commit stall and same-cycle resume.
        disp(2, 1);
        cmt_ready_i = 1'b0;
        wb(1, 1, 0, 0, 0, 0);
        settle();
        check_eq("young_only_cmt", cmt_valid_o, 0);
        wb(1, 0, 0, 0, 0, 0);
        settle();
        check_eq("stall_cmt", cmt_valid_o, 0);
        tick();
        settle();
        check_eq("stall_count", count_o, 2);
        cmt_ready_i = 1'b1;
        settle();
        check_eq("resume_cmt", cmt_valid_o, 2'b11);
        tick();
        settle();
        check_eq("resume_count", count_o, 0);
        check_eq("resume_empty", empty_o, 1);

        // Fill to full, reject a group, free two slots, wrap the tail.
        do_flush();
        settle();
        check_eq("flush_count", count_o, 0);
        for (int g = 0; g < 4; g++) disp(2, 1);
        settle();
        check_eq("full_flag", full_o, 1);
        check_eq("full_count", count_o, 8);
        disp(2, 0);
        settle();
        check_eq("full_held", count_o, 8);
        wb(1, 0, 0, 1, 1, 0);
        tick();
        settle();
        check_eq("after_cmt_count", count_o, 6);
        check_eq("after_cmt_ready", disp_ready_o, 1);
        disp(2, 1);
        settle();
        check_eq("wrap_count", count_o, 8);

        // Stale writeback to index 0 (now tag 8) must be dropped.
        wb_valid_i = 2'b01; wb_tag_i[0] = 4'd0; wb_data_i[0] = 32'hBAD0_BAD0; wb_exc_i = '0;
        tick();
        wb_valid_i = '0;
        wb(1, 2, 0, 1, 3, 0);
        wb(1, 4, 0, 1, 5, 0);
        wb(1, 6, 0, 1, 7, 0);
        tick();
        settle();
        check_eq("stale_count", count_o, 2);
        check_eq("stale_no_cmt", cmt_valid_o, 0);
        wb(1, 8, 0, 1, 9, 0);
        tick();
        settle();
        check_eq("drain_count", count_o, 0);

        // Exception in the middle of a completed group.
        disp(2, 1);
        disp(1, 1);
        wb(1, 10, 0, 1, 11, 1);
        settle();
        check_eq("exc_older_cmt", cmt_valid_o, 2'b01);
        check_eq("exc_not_yet", exc_o, 0);
        wb(1, 12, 0, 0, 0, 0);
        settle();
        check_eq("exc_flag", exc_o, 1);
        check_eq("exc_pc", exc_pc_o, m_pc[11]);
        check_eq("exc_blocks", cmt_valid_o, 0);
        tick();
        settle();
        check_eq("exc_hold", {exc_o, cmt_valid_o}, 3'b100);
        check_eq("exc_count", count_o, 2);
        check_eq("exc_pending", sb_q.size(), 2);
        do_flush();
        settle();
        check_eq("exc_cleared", {exc_o, exc_pc_o}, 0);
        check_eq("exc_flush_count", count_o, 0);

`ifdef ROB_ROLLBACK_EN
        // Roll back to tag 2 while a dispatch group is presented.
        for (int g = 0; g < 3; g++) disp(2, 1);
        drive_lanes(2);
        rb_valid_i = 1'b1; rb_tag_i = 4'd2;
        tick();
        rb_valid_i = 1'b0; disp_valid_i = '0;
        seq += 2;
        for (int i = 0; i < 3; i++) void'(sb_q.pop_back());
        m_tail = 4'd3;
        settle();
        check_eq("rb_count", count_o, 3);
        check_eq("rb_tail", disp_tag_o[0], 3);
        wb(1, 4, 0, 0, 0, 0);
        settle();
        check_eq("rb_stale_count", count_o, 3);
        check_eq("rb_stale_cmt", cmt_valid_o, 0);
        wb(1, 0, 0, 1, 1, 0);
        wb(1, 2, 0, 0, 0, 0);
        tick();
        settle();
        check_eq("rb_drain", count_o, 0);
`endif

        check_eq("sb_empty", sb_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
